// File: rtl/mpm_pkg.sv
// Shared types for the masked pattern matcher: run-tracking states and the
// pattern entry record (stored at MPM_MAX_W bits, upper bits held at zero).
package mpm_pkg;

  localparam int MPM_MAX_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    DET   = 2'd2
  } run_state_e;

  typedef struct packed {
    logic                 en;
    logic [MPM_MAX_W-1:0] value;
    logic [MPM_MAX_W-1:0] mask;
  } entry_t;

endpackage

// File: rtl/masked_cmp.sv
// Single-entry masked comparator: mask bit 1 compares, 0 is don't-care.
module masked_cmp #(
  parameter int W = 4
) (
  input  logic [W-1:0] data_i,
  input  logic [W-1:0] value_i,
  input  logic [W-1:0] mask_i,
  input  logic         en_i,
  output logic         match_o
);

  assign match_o = en_i && (((data_i ^ value_i) & mask_i) == '0);

endmodule

// File: rtl/masked_pattern_matcher.sv
// Streaming multi-entry masked pattern matcher with priority index,
// saturating hit counter and same-entry run detector. One cycle latency.
module masked_pattern_matcher
  import mpm_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int NUM_PAT = 4,
  parameter int CNT_W   = 8,
  parameter int RUN_LEN = 3,
  localparam int IDX_W  = (NUM_PAT > 1) ? $clog2(NUM_PAT) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_we,
  input  logic [IDX_W-1:0]   cfg_addr,
  input  logic [WIDTH-1:0]   cfg_value,
  input  logic [WIDTH-1:0]   cfg_mask,
  input  logic               cfg_en,
  input  logic               in_valid,
  input  logic [WIDTH-1:0]   in_data,
  input  logic               cnt_clr,
  output logic               out_valid,
  output logic               out_hit,
  output logic [IDX_W-1:0]   out_idx,
  output logic [NUM_PAT-1:0] out_vec,
  output logic [CNT_W-1:0]   hit_cnt,
  output logic               run_det
);

  localparam int RUN_W = $clog2(RUN_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  entry_t               ent_q [NUM_PAT];
  entry_t               wr_entry;
  logic                 addr_ok;
  logic [MPM_MAX_W-1:0] data_ext;
  logic [NUM_PAT-1:0]   match;
  logic                 any_hit;
  logic [IDX_W-1:0]     hit_idx;

  run_state_e           state_q, state_d;
  logic [IDX_W-1:0]     trk_idx_q, trk_idx_d;
  logic [RUN_W-1:0]     run_n_q, run_n_d;
  logic                 run_det_q, run_det_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 out_valid_q, out_hit_q;
  logic [IDX_W-1:0]     out_idx_q;
  logic [NUM_PAT-1:0]   out_vec_q;

  assign data_ext       = MPM_MAX_W'(in_data);
  assign addr_ok        = (32'(cfg_addr) < 32'(NUM_PAT));
  assign wr_entry.en    = cfg_en;
  assign wr_entry.value = MPM_MAX_W'(cfg_value);
  assign wr_entry.mask  = MPM_MAX_W'(cfg_mask);

  // Entry table: beats sampled on a write edge still see the old entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_PAT; i++) ent_q[i] <= '0;
    end else if (cfg_we && addr_ok) begin
      ent_q[cfg_addr] <= wr_entry;
    end
  end

  for (genvar gi = 0; gi < NUM_PAT; gi++) begin : g_cmp
    masked_cmp #(.W(MPM_MAX_W)) u_cmp (
      .data_i  (data_ext),
      .value_i (ent_q[gi].value),
      .mask_i  (ent_q[gi].mask),
      .en_i    (ent_q[gi].en),
      .match_o (match[gi])
    );
  end

  assign any_hit = |match;

  always_comb begin
    hit_idx = '0;
    for (int i = NUM_PAT - 1; i >= 0; i--) begin
      if (match[i]) hit_idx = IDX_W'(i);
    end
  end

  // Run tracker advances only on valid beats.
  always_comb begin
    state_d   = state_q;
    trk_idx_d = trk_idx_q;
    run_n_d   = run_n_q;
    run_det_d = 1'b0;
    if (in_valid) begin
      if (!any_hit) begin
        state_d = IDLE;
        run_n_d = '0;
      end else if (state_q != IDLE && hit_idx == trk_idx_q) begin
        if (state_q == TRACK) begin
          run_n_d = run_n_q + 1'b1;
          if (run_n_d == RUN_W'(RUN_LEN)) begin
            state_d   = DET;
            run_det_d = 1'b1;
          end
        end
      end else begin
        trk_idx_d = hit_idx;
        run_n_d   = RUN_W'(1);
        if (RUN_LEN == 1) begin
          state_d   = DET;
          run_det_d = 1'b1;
        end else begin
          state_d = TRACK;
        end
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) cnt_d = '0;
    else if (in_valid && any_hit && cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      trk_idx_q   <= '0;
      run_n_q     <= '0;
      run_det_q   <= 1'b0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_hit_q   <= 1'b0;
      out_idx_q   <= '0;
      out_vec_q   <= '0;
    end else begin
      state_q     <= state_d;
      trk_idx_q   <= trk_idx_d;
      run_n_q     <= run_n_d;
      run_det_q   <= run_det_d;
      cnt_q       <= cnt_d;
      out_valid_q <= in_valid;
      out_hit_q   <= in_valid & any_hit;
      out_idx_q   <= (in_valid & any_hit) ? hit_idx : '0;
      out_vec_q   <= in_valid ? match : '0;
    end
  end

  assign out_valid = out_valid_q;
  assign out_hit   = out_hit_q;
  assign out_idx   = out_idx_q;
  assign out_vec   = out_vec_q;
  assign hit_cnt   = cnt_q;
  assign run_det   = run_det_q;

endmodule

// File: tb/tb_masked_pattern_matcher.sv
// Bench for masked_pattern_matcher: directed beats, a cycle-by-cycle reference
// model for two counter widths, and hand-computed spot checks.
module tb_masked_pattern_matcher;

  localparam int RUN_LEN = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cfg_we = 1'b0;
  logic [1:0] cfg_addr = '0;
  logic [3:0] cfg_value = '0;
  logic [3:0] cfg_mask = '0;
  logic       cfg_en = 1'b0;
  logic       in_valid = 1'b0;
  logic [3:0] in_data = '0;
  logic       cnt_clr = 1'b0;

  logic       a_valid, a_hit, a_run;
  logic [1:0] a_idx;
  logic [3:0] a_vec;
  logic [7:0] a_cnt;
  logic       b_valid, b_hit, b_run;
  logic [1:0] b_idx;
  logic [3:0] b_vec;
  logic [1:0] b_cnt;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  masked_pattern_matcher #(.WIDTH(4), .NUM_PAT(4), .CNT_W(8), .RUN_LEN(RUN_LEN)) u_dut8 (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_value(cfg_value),
    .cfg_mask(cfg_mask), .cfg_en(cfg_en), .in_valid(in_valid), .in_data(in_data),
    .cnt_clr(cnt_clr), .out_valid(a_valid), .out_hit(a_hit), .out_idx(a_idx),
    .out_vec(a_vec), .hit_cnt(a_cnt), .run_det(a_run)
  );

  masked_pattern_matcher #(.WIDTH(4), .NUM_PAT(4), .CNT_W(2), .RUN_LEN(RUN_LEN)) u_dut2 (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_value(cfg_value),
    .cfg_mask(cfg_mask), .cfg_en(cfg_en), .in_valid(in_valid), .in_data(in_data),
    .cnt_clr(cnt_clr), .out_valid(b_valid), .out_hit(b_hit), .out_idx(b_idx),
    .out_vec(b_vec), .hit_cnt(b_cnt), .run_det(b_run)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: entries as arrays, run tracked as (index, length).
  logic       m_en [4];
  logic [3:0] m_val [4];
  logic [3:0] m_msk [4];
  int         run_n = 0, run_idx = 0, c8 = 0, c2 = 0;
  logic       e_valid = 0, e_hit = 0, e_run = 0;
  int         e_idx = 0;
  logic [3:0] e_vec = '0;
  logic [3:0] mv;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        m_en[i] = 1'b0; m_val[i] = '0; m_msk[i] = '0;
      end
      run_n = 0; run_idx = 0; c8 = 0; c2 = 0;
      e_valid = 0; e_hit = 0; e_idx = 0; e_vec = '0; e_run = 0;
    end else begin
      mv = '0;
      for (int i = 0; i < 4; i++)
        if (m_en[i] && (((in_data ^ m_val[i]) & m_msk[i]) == 4'b0000)) mv[i] = 1'b1;
      e_valid = in_valid;
      e_vec   = in_valid ? mv : 4'b0000;
      e_hit   = in_valid && (mv != 4'b0000);
      e_idx   = 0;
      if (e_hit) begin
        for (int i = 3; i >= 0; i--) if (mv[i]) e_idx = i;
      end
      e_run = 1'b0;
      if (in_valid) begin
        if (!e_hit) run_n = 0;
        else if (run_n > 0 && run_idx == e_idx) run_n++;
        else begin run_idx = e_idx; run_n = 1; end
        e_run = e_hit && (run_n == RUN_LEN);
      end
      if (cnt_clr) begin c8 = 0; c2 = 0; end
      else if (e_hit) begin
        if (c8 < 255) c8++;
        if (c2 < 3) c2++;
      end
      if (cfg_we) begin
        m_en[cfg_addr] = cfg_en; m_val[cfg_addr] = cfg_value; m_msk[cfg_addr] = cfg_mask;
      end
    end
    #1;
    check("valid8", a_valid, e_valid);  check("valid2", b_valid, e_valid);
    check("hit8",   a_hit,   e_hit);    check("hit2",   b_hit,   e_hit);
    check("idx8",   a_idx,   e_idx);    check("idx2",   b_idx,   e_idx);
    check("vec8",   a_vec,   e_vec);    check("vec2",   b_vec,   e_vec);
    check("run8",   a_run,   e_run);    check("run2",   b_run,   e_run);
    check("cnt8",   a_cnt,   c8);       check("cnt2",   b_cnt,   c2);
  end

  task automatic beat(input logic v, input logic [3:0] d);
    in_valid = v; in_data = d;
    @(posedge clk); #2;
    in_valid = 1'b0; cfg_we = 1'b0; cnt_clr = 1'b0; rst = 1'b0;
  endtask

  task automatic set_cfg(input logic [1:0] a, input logic [3:0] val, input logic [3:0] msk,
                         input logic en);
    cfg_we = 1'b1; cfg_addr = a; cfg_value = val; cfg_mask = msk; cfg_en = en;
  endtask

  initial begin
    // Reset
    rst = 1'b1; beat(1'b1, 4'b0000);
    rst = 1'b1; beat(1'b0, 4'b0000);
    check("rst_valid", a_valid, 0); check("rst_cnt", a_cnt, 0); check("rst_run", a_run, 0);

    // Test 1
    set_cfg(2'd0, 4'b1100, 4'b1110, 1'b1); beat(1'b0, 4'b0000);
    beat(1'b1, 4'b1100); check("t1_hit_a", a_hit, 1); check("t1_idx_a", a_idx, 0);
    beat(1'b1, 4'b1101); check("t1_hit_b", a_hit, 1); check("t1_idx_b", a_idx, 0);
    beat(1'b1, 4'b0101); check("t1_miss", a_hit, 0); check("t1_cnt", a_cnt, 2);

    // Test 2
    set_cfg(2'd1, 4'b1101, 4'b1111, 1'b1); beat(1'b0, 4'b0000);
    beat(1'b1, 4'b1101); check("t2_vec", a_vec, 4'b0011); check("t2_idx", a_idx, 0);

    // Test 3
    beat(1'b1, 4'b0000);
    beat(1'b1, 4'b1100);
    beat(1'b0, 4'b1100); check("t3_gap_valid", a_valid, 0);
    beat(1'b1, 4'b1100); check("t3_run_b2", a_run, 0);
    beat(1'b1, 4'b1100); check("t3_run_b3", a_run, 1);
    beat(1'b1, 4'b1100); check("t3_run_b4", a_run, 0);
    beat(1'b1, 4'b0000);
    beat(1'b1, 4'b1100); beat(1'b1, 4'b1100);
    beat(1'b1, 4'b1100); check("t3_run2", a_run, 1); check("t3_cnt", a_cnt, 10);

    // Test 4
    set_cfg(2'd1, 4'b1101, 4'b1111, 1'b0); beat(1'b0, 4'b0000);
    set_cfg(2'd0, 4'b1100, 4'b1111, 1'b1); beat(1'b1, 4'b1101);
    check("t4_old_hit", a_hit, 1);
    beat(1'b1, 4'b1101); check("t4_new_miss", a_hit, 0);

    // Test 5
    cnt_clr = 1'b1; beat(1'b1, 4'b1100); check("t5_clr8", a_cnt, 0); check("t5_clr2", b_cnt, 0);
    for (int i = 0; i < 5; i++) beat(1'b1, 4'b1100);
    check("t5_sat2", b_cnt, 3); check("t5_cnt8", a_cnt, 5);
    cnt_clr = 1'b1; beat(1'b1, 4'b1100); check("t5_clrhit2", b_cnt, 0);

    // Test 6
    beat(1'b1, 4'b0000);
    beat(1'b1, 4'b1100); beat(1'b1, 4'b1100);
    rst = 1'b1; beat(1'b1, 4'b1100);
    check("t6_valid", a_valid, 0); check("t6_cnt", a_cnt, 0); check("t6_run", a_run, 0);
    beat(1'b1, 4'b1100); check("t6_nohit_v", a_valid, 1); check("t6_nohit", a_hit, 0);
    set_cfg(2'd0, 4'b1100, 4'b1111, 1'b1); beat(1'b0, 4'b0000);
    beat(1'b1, 4'b1100); check("t6_first_hit", a_hit, 1); check("t6_no_pulse", a_run, 0);
    beat(1'b1, 4'b1100); beat(1'b1, 4'b1100); check("t6_pulse", a_run, 1);

    // Mask-zero entry matches everything
    set_cfg(2'd3, 4'b1010, 4'b0000, 1'b1); beat(1'b0, 4'b0000);
    beat(1'b1, 4'b0110); check("m0_idx", a_idx, 3); check("m0_vec", a_vec, 4'b1000);

    beat(1'b0, 4'b0000);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
